// File: rtl/font_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter_if
//   Request/response bundle between the two glyph-row requesters and the font
//   ROM arbiter. Each requester presents {digit,row} with a valid (reqN) and is
//   answered with a combinational ready (ackN). Later it receives a one-cycle
//   rvalidN pulse with the glyph row on rdataN.
//
//   Parameters
//     DATA_W   glyph row width, matches the font ROM word
//
//   Modports
//     master   requester side: drives req/digit/row, receives ack/rvalid/rdata
//     slave    arbiter side:   receives req/digit/row, drives ack/rvalid/rdata
// -----------------------------------------------------------------------------
interface font_rom_arbiter_if #(
    parameter int DATA_W = 24
);
    logic              req0;
    logic [3:0]        digit0;
    logic [4:0]        row0;
    logic              ack0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic [3:0]        digit1;
    logic [4:0]        row1;
    logic              ack1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, digit0, row0, req1, digit1, row1,
        input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1
    );

    modport slave (
        input  req0, digit0, row0, req1, digit1, row1,
        output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// font_rom_arbiter
//   Shares one 512 x DATA_W digit-glyph font ROM between two pixel requesters.
//   One request is granted per cycle and its address {digit,row} is issued to
//   the ROM. The ROM registers that address, so data comes back one cycle
//   later. The row is returned to the originator 2 edges after the transfer
//   edge as a one-cycle rvalid pulse. Digits above MAX_DIGIT are accepted but
//   never reach the ROM; they return an all-zero row.
//
//   Ports
//     clk       system clock
//     reset     synchronous, active-high reset
//     bus       font_rom_arbiter_if.slave: req/digit/row/ack/rvalid/rdata x2
//     rom_addr  registered address to font_rom
//     rom_data  read data from font_rom
//
//   Configuration
//     FONT_ARB_PRIORITY_EN  when defined, req0 always wins contention (req1 may
//                           starve); otherwise contention is resolved
//                           round-robin.
// -----------------------------------------------------------------------------
module font_rom_arbiter #(
    parameter int DATA_W    = 24,
    parameter int MAX_DIGIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    font_rom_arbiter_if.slave bus,
    output logic [8:0]        rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [3:0] MAX_D = 4'(MAX_DIGIT);

    logic       grant0;
    logic       grant1;
    logic       xfer;
    logic       xfer_id;
    logic       xfer_oor;
    logic [8:0] xfer_addr;

    // Response tag pipeline: stage 1 tracks the ROM address cycle and stage 2
    // tracks the ROM data cycle.
    logic s1_v, s1_id, s1_oor;
    logic s2_v, s2_id, s2_oor;

`ifdef FONT_ARB_PRIORITY_EN
    // Fixed priority: req0 always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = bus.req0;
            grant1 = bus.req1 && !bus.req0;
        end
    end
`else
    // rr_last = 1 means requester 1 won the most recent transfer, so
    // requester 0 is favoured on the next contention.
    logic rr_last;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                grant0 = rr_last;
                grant1 = !rr_last;
            end else begin
                grant0 = bus.req0;
                grant1 = bus.req1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (grant0) begin
            rr_last <= 1'b0;
        end else if (grant1) begin
            rr_last <= 1'b1;
        end
    end
`endif

    assign bus.ack0 = grant0;
    assign bus.ack1 = grant1;

    assign xfer    = grant0 || grant1;
    assign xfer_id = grant1;

    always_comb begin
        if (grant1) begin
            xfer_addr = {bus.digit1, bus.row1};
            xfer_oor  = bus.digit1 > MAX_D;
        end else begin
            xfer_addr = {bus.digit0, bus.row0};
            xfer_oor  = bus.digit0 > MAX_D;
        end
    end

    // An out-of-range request leaves rom_addr untouched. The ROM then returns
    // stale data, and that data is replaced by zero on the way out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr    <= '0;
            s1_v        <= 1'b0;
            s1_id       <= 1'b0;
            s1_oor      <= 1'b0;
            s2_v        <= 1'b0;
            s2_id       <= 1'b0;
            s2_oor      <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            if (xfer && !xfer_oor) begin
                rom_addr <= xfer_addr;
            end
            s1_v        <= xfer;
            s1_id       <= xfer_id;
            s1_oor      <= xfer_oor;
            s2_v        <= s1_v;
            s2_id       <= s1_id;
            s2_oor      <= s1_oor;
            bus.rvalid0 <= s2_v && !s2_id;
            bus.rvalid1 <= s2_v && s2_id;
            if (s2_v && !s2_id) begin
                bus.rdata0 <= s2_oor ? '0 : rom_data;
            end
            if (s2_v && s2_id) begin
                bus.rdata1 <= s2_oor ? '0 : rom_data;
            end
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_font_rom_arbiter
//   Self-checking bench for font_rom_arbiter. A registered-address ROM model
//   feeds the design. Every cycle, a reference model predicts the grant, the
//   ROM address and the tagged responses from the arbitration rules, and
//   compares them with the design outputs. Directed sequences are followed by
//   randomized traffic with random resets. Build with FONT_ARB_PRIORITY_EN
//   defined to exercise the fixed-priority variant.
// -----------------------------------------------------------------------------
module tb_font_rom_arbiter;

    localparam int DATA_W    = 24;
    localparam int MAX_DIGIT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [8:0]        rom_addr;
    logic [DATA_W-1:0] rom_data;

    font_rom_arbiter_if #(.DATA_W(DATA_W)) bus ();

    font_rom_arbiter #(
        .DATA_W   (DATA_W),
        .MAX_DIGIT(MAX_DIGIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // Font ROM with a registered address: one-cycle read.
    logic [DATA_W-1:0] rom_mem [512];
    logic [DATA_W-1:0] rom_q;

    always @(posedge clk) rom_q <= rom_mem[rom_addr];
    assign rom_data = rom_q;

    // Reference model state
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             pending[$];
    int                edge_count;
    int                last_winner;
    logic [8:0]        exp_addr;
    logic [DATA_W-1:0] exp_rdata0;
    logic [DATA_W-1:0] exp_rdata1;
    int                rv1_count;

    int checks_done;
    int checks_passed;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_done++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)",
                     tag, actual, expected, edge_count);
        end
    endtask

    // One clock cycle: check what the previous edge produced, drive new
    // inputs, check the grant, update the model, then let the edge happen.
    task automatic applyStimulus(input logic r0, input logic [3:0] d0, input logic [4:0] w0,
                                 input logic r1, input logic [3:0] d1, input logic [4:0] w1,
                                 input logic rst, output logic g0, output logic g1);
        logic       exp_v0;
        logic       exp_v1;
        logic [3:0] d;
        logic [4:0] w;
        int         id;
        @(negedge clk);
        exp_v0 = 1'b0;
        exp_v1 = 1'b0;
        while (pending.size() > 0 && pending[0].due <= edge_count) begin
            if (pending[0].due == edge_count) begin
                if (pending[0].id == 0) begin
                    exp_v0     = 1'b1;
                    exp_rdata0 = pending[0].data;
                end else begin
                    exp_v1     = 1'b1;
                    exp_rdata1 = pending[0].data;
                end
            end
            void'(pending.pop_front());
        end
        if (bus.rvalid1) rv1_count++;
        checkOutput("rvalid0", 32'(bus.rvalid0), 32'(exp_v0));
        checkOutput("rvalid1", 32'(bus.rvalid1), 32'(exp_v1));
        checkOutput("rdata0", 32'(bus.rdata0), 32'(exp_rdata0));
        checkOutput("rdata1", 32'(bus.rdata1), 32'(exp_rdata1));
        checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));

        reset      = rst;
        bus.req0   = r0;
        bus.digit0 = d0;
        bus.row0   = w0;
        bus.req1   = r1;
        bus.digit1 = d1;
        bus.row1   = w1;
        #1;

        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (r0 && !r1) begin
                g0 = 1'b1;
            end else if (r1 && !r0) begin
                g1 = 1'b1;
            end else if (r0 && r1) begin
`ifdef FONT_ARB_PRIORITY_EN
                g0 = 1'b1;
`else
                if (last_winner == 1) g0 = 1'b1;
                else g1 = 1'b1;
`endif
            end
        end
        checkOutput("ack0", 32'(bus.ack0), 32'(g0));
        checkOutput("ack1", 32'(bus.ack1), 32'(g1));

        if (rst) begin
            pending.delete();
            last_winner = 1;
            exp_addr    = '0;
            exp_rdata0  = '0;
            exp_rdata1  = '0;
        end else if (g0 || g1) begin
            id = g0 ? 0 : 1;
            d  = g0 ? d0 : d1;
            w  = g0 ? w0 : w1;
            if (int'(d) > MAX_DIGIT) begin
                pending.push_back('{due: edge_count + 3, id: id, data: '0});
            end else begin
                pending.push_back('{due: edge_count + 3, id: id,
                                    data: rom_mem[int'(d) * 32 + int'(w)]});
                exp_addr = 9'(int'(d) * 32 + int'(w));
            end
            last_winner = id;
        end

        @(posedge clk);
        edge_count++;
    endtask

    task automatic idleCycles(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, g0, g1);
        end
    endtask

    task automatic resetCycle();
        logic g0, g1;
        applyStimulus(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 1'b1, g0, g1);
    endtask

    initial begin
        logic       g0, g1;
        logic       h0, h1, rst_now;
        logic [3:0] rd0, rd1;
        logic [4:0] rw0, rw1;

        for (int a = 0; a < 512; a++) begin
            rom_mem[a] = DATA_W'((a * 32'h9E3779B1) ^ 32'h00A5C3);
        end
        rom_mem[0]   = 24'h0FFFF0;
        rom_mem[32]  = 24'h000F00;
        rom_mem[92]  = 24'hFFFFFF;
        rom_mem[255] = 24'hF00000;

        checks_done   = 0;
        checks_passed = 0;
        edge_count    = 0;
        last_winner   = 1;
        exp_addr      = '0;
        exp_rdata0    = '0;
        exp_rdata1    = '0;
        rv1_count     = 0;

        reset      = 1'b1;
        bus.req0   = 1'b0;
        bus.digit0 = '0;
        bus.row0   = '0;
        bus.req1   = 1'b0;
        bus.digit1 = '0;
        bus.row1   = '0;
        repeat (2) @(posedge clk);
        resetCycle();

        // Single request for digit 1, row 0
        applyStimulus(1'b1, 4'd1, 5'd0, 1'b0, 4'd0, 5'd0, 1'b0, g0, g1);
        idleCycles(3);
        #2 checkOutput("t1_rdata0", 32'(bus.rdata0), 32'h000F00);

        // Contention for 4 cycles after reset
        resetCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'd0, 5'd0, 1'b1, 4'd2, 5'd28, 1'b0, g0, g1);
        end
        idleCycles(3);
        #2 checkOutput("t2_rdata0", 32'(bus.rdata0), 32'h0FFFF0);
        checkOutput("t2_rdata1", 32'(bus.rdata1), 32'hFFFFFF);

        // Requester 1 streams all rows of digit 7 back-to-back
        rv1_count = 0;
        for (int r = 0; r < 32; r++) begin
            applyStimulus(1'b0, 4'd0, 5'd0, 1'b1, 4'd7, 5'(r), 1'b0, g0, g1);
        end
        idleCycles(3);
        #2 checkOutput("t3_pulses", 32'(rv1_count), 32'd32);
        checkOutput("t3_rdata1", 32'(bus.rdata1), 32'hF00000);

        // Out-of-range digit
        applyStimulus(1'b1, 4'd9, 5'd3, 1'b0, 4'd0, 5'd0, 1'b0, g0, g1);
        idleCycles(3);
        #2 checkOutput("t4_rdata0", 32'(bus.rdata0), 32'h0);

        // Reset one cycle after a transfer discards it
        applyStimulus(1'b1, 4'd3, 5'd4, 1'b0, 4'd0, 5'd0, 1'b0, g0, g1);
        resetCycle();
        idleCycles(4);

        // Continuous contention
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'd5, 5'(i), 1'b1, 4'd6, 5'(31 - i), 1'b0, g0, g1);
        end
        idleCycles(3);

        // Randomized traffic, holding each request until it is acked
        h0 = 1'b0; h1 = 1'b0;
        rd0 = '0; rd1 = '0; rw0 = '0; rw1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!h0 && $urandom_range(3) != 0) begin
                h0  = 1'b1;
                rd0 = 4'($urandom_range(11));
                rw0 = 5'($urandom_range(31));
            end
            if (!h1 && $urandom_range(3) != 0) begin
                h1  = 1'b1;
                rd1 = 4'($urandom_range(11));
                rw1 = 5'($urandom_range(31));
            end
            rst_now = ($urandom_range(79) == 0);
            applyStimulus(h0, rd0, rw0, h1, rd1, rw1, rst_now, g0, g1);
            if (g0) h0 = 1'b0;
            if (g1) h1 = 1'b0;
        end
        idleCycles(4);

        $display("%0d/%0d checks passed", checks_passed, checks_done);
        $finish;
    end

endmodule
